// File: rtl/ram_fifo_ctrl.sv
// Stream FIFO controller wrapped around an external simple dual-port RAM with 1-cycle registered reads.
// A 2-entry output buffer absorbs the read latency so push and pop can both run every cycle.
module ram_fifo_ctrl #(
  parameter  int RAM_SIZE   = 64,
  parameter  int DATA_WIDTH = 8,
  localparam int ADDR_WIDTH = $clog2(RAM_SIZE),
  localparam int CNT_WIDTH  = $clog2(RAM_SIZE + 3)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic                  ram_w_enable,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0]  ram_level;
  logic                  pend;
  logic [1:0]            buf_count;
  logic [DATA_WIDTH-1:0] buf_head;
  logic [DATA_WIDTH-1:0] buf_second;
  logic                  push;
  logic                  pop;
  logic                  rd_issue;

  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == ADDR_WIDTH'(RAM_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready     = rst_n & (ram_level != CNT_WIDTH'(RAM_SIZE));
  assign push         = in_valid & in_ready;
  assign out_valid    = (buf_count != 2'd0);
  assign pop          = out_valid & out_ready;
  assign out_data     = buf_head;
  assign count        = ram_level + CNT_WIDTH'(pend) + CNT_WIDTH'(buf_count);

  // Only issue a read when the buffer is guaranteed a free slot the cycle the data lands.
  assign rd_issue     = (ram_level != '0) &
                        (({1'b0, buf_count} + {2'b00, pend}) < (3'd2 + {2'b00, pop}));

  assign ram_w_enable = push;
  assign ram_w_addr   = wr_ptr;
  assign ram_data_in  = in_data;
  assign ram_r_addr   = rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_level <= '0;
      pend      <= 1'b0;
      buf_count <= 2'd0;
    end else begin
      if (push)
        wr_ptr <= next_ptr(wr_ptr);
      if (rd_issue)
        rd_ptr <= next_ptr(rd_ptr);
      pend      <= rd_issue;
      ram_level <= ram_level + CNT_WIDTH'(push) - CNT_WIDTH'(rd_issue);
      buf_count <= buf_count + {1'b0, pend} - {1'b0, pop};
    end
  end

  // Buffer storage is a 2-deep shift: head is always the oldest word.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      case ({pend, pop})
        2'b10: begin
          if (buf_count == 2'd0)
            buf_head <= ram_data_out;
          else
            buf_second <= ram_data_out;
        end
        2'b01: buf_head <= buf_second;
        2'b11: begin
          if (buf_count == 2'd1) begin
            buf_head <= ram_data_out;
          end else begin
            buf_head   <= buf_second;
            buf_second <= ram_data_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: a 64-deep and a 5-deep instance, each with a behavioural RAM,
// checked against a queue model of the stream contents.
module tb_ram_fifo_ctrl;

  localparam int BIG   = 64;
  localparam int SMALL = 5;
  localparam int DW    = 8;
  localparam int BAW   = $clog2(BIG);
  localparam int BCW   = $clog2(BIG + 3);
  localparam int SAW   = $clog2(SMALL);
  localparam int SCW   = $clog2(SMALL + 3);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]  b_in_data, b_out_data, b_ram_din, b_ram_dout;
  logic           b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ram_we;
  logic [BCW-1:0] b_count;
  logic [BAW-1:0] b_ram_waddr, b_ram_raddr;

  logic [DW-1:0]  s_in_data, s_out_data, s_ram_din, s_ram_dout;
  logic           s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_ram_we;
  logic [SCW-1:0] s_count;
  logic [SAW-1:0] s_ram_waddr, s_ram_raddr;

  ram_fifo_ctrl #(.RAM_SIZE(BIG), .DATA_WIDTH(DW)) u_big (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .count(b_count),
    .ram_data_in(b_ram_din), .ram_w_addr(b_ram_waddr), .ram_w_enable(b_ram_we),
    .ram_r_addr(b_ram_raddr), .ram_data_out(b_ram_dout)
  );

  ram_fifo_ctrl #(.RAM_SIZE(SMALL), .DATA_WIDTH(DW)) u_small (
    .clk(clk), .rst_n(rst_n),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .count(s_count),
    .ram_data_in(s_ram_din), .ram_w_addr(s_ram_waddr), .ram_w_enable(s_ram_we),
    .ram_r_addr(s_ram_raddr), .ram_data_out(s_ram_dout)
  );

  // Behavioural RAMs: registered read, no reset.
  logic [DW-1:0] big_mem [BIG];
  logic [DW-1:0] small_mem [SMALL];
  always @(posedge clk) begin
    if (b_ram_we) big_mem[b_ram_waddr] <= b_ram_din;
    b_ram_dout <= big_mem[b_ram_raddr];
    if (s_ram_we) small_mem[s_ram_waddr] <= s_ram_din;
    s_ram_dout <= small_mem[s_ram_raddr];
  end

  logic [DW-1:0] big_q[$];
  logic [DW-1:0] small_q[$];
  int total = 0;
  int bad = 0;
  logic          big_last_valid, big_last_ready;
  logic [DW-1:0] big_last_data;
  logic [31:0]   big_last_count;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic iv, input logic [DW-1:0] d, input logic ordy);
    b_in_valid  = iv;
    b_in_data   = d;
    b_out_ready = ordy;
  endtask

  // One clock of the 64-deep instance: sample at negedge, score handshakes, advance past posedge.
  task automatic tick_big();
    logic push, pop;
    @(negedge clk);
    big_last_valid = b_out_valid;
    big_last_ready = b_in_ready;
    big_last_data  = b_out_data;
    big_last_count = 32'(b_count);
    check_output("big_count", 32'(b_count), big_q.size());
    if (!rst_n) begin
      check_output("big_rst_in_ready", 32'(b_in_ready), 0);
      check_output("big_rst_w_enable", 32'(b_ram_we), 0);
    end else begin
      if (big_q.size() < BIG) check_output("big_ready_not_full", 32'(b_in_ready), 1);
      if (big_q.size() == BIG + 2) check_output("big_ready_full", 32'(b_in_ready), 0);
    end
    push = rst_n & b_in_valid & b_in_ready;
    pop  = rst_n & b_out_valid & b_out_ready;
    if (pop) begin
      if (big_q.size() == 0) check_output("big_spurious_valid", 32'(b_out_valid), 0);
      else check_output("big_out_data", 32'(b_out_data), 32'(big_q.pop_front()));
    end
    if (push) big_q.push_back(b_in_data);
    @(posedge clk);
    if (!rst_n) big_q.delete();
    #1;
  endtask

  task automatic tick_small();
    logic push, pop;
    @(negedge clk);
    check_output("small_count", 32'(s_count), small_q.size());
    if (small_q.size() < SMALL) check_output("small_ready_not_full", 32'(s_in_ready), 1);
    if (small_q.size() == SMALL + 2) check_output("small_ready_full", 32'(s_in_ready), 0);
    push = s_in_valid & s_in_ready;
    pop  = s_out_valid & s_out_ready;
    if (pop) begin
      if (small_q.size() == 0) check_output("small_spurious_valid", 32'(s_out_valid), 0);
      else check_output("small_out_data", 32'(s_out_data), 32'(small_q.pop_front()));
    end
    if (push) small_q.push_back(s_in_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int accepted;
    int n;
    int phase;
    logic found;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    apply_stimulus(1'b1, 8'h11, 1'b0);

    // Reset held with a write request pending.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      tick_big();
      check_output("rst_out_valid", 32'(big_last_valid), 0);
    end
    rst_n = 1'b1;
    apply_stimulus(1'b0, 8'h00, 1'b1);
    tick_big();

    // Single word latency.
    apply_stimulus(1'b1, 8'hA5, 1'b1);
    tick_big();
    apply_stimulus(1'b0, 8'h00, 1'b1);
    tick_big();
    check_output("single_t1_valid", 32'(big_last_valid), 0);
    check_output("single_t1_count", big_last_count, 1);
    tick_big();
    check_output("single_t2_valid", 32'(big_last_valid), 0);
    tick_big();
    check_output("single_t3_valid", 32'(big_last_valid), 1);
    check_output("single_t3_data", 32'(big_last_data), 32'h A5);
    tick_big();
    check_output("single_t4_count", big_last_count, 0);
    check_output("single_t4_valid", 32'(big_last_valid), 0);

    // Back-to-back streaming through the pointer wrap.
    for (int i = 0; i < 200; i++) begin
      apply_stimulus(1'b1, 8'(i), 1'b1);
      tick_big();
      check_output("stream_in_ready", 32'(big_last_ready), 1);
      if (i >= 3) check_output("stream_out_valid", 32'(big_last_valid), 1);
    end
    apply_stimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick_big();
      check_output("stream_tail_valid", 32'(big_last_valid), 1);
    end
    tick_big();
    check_output("stream_end_valid", 32'(big_last_valid), 0);

    // Fill under backpressure.
    accepted = 0;
    for (int i = 0; i < 80; i++) begin
      apply_stimulus(1'b1, 8'(i + 7), 1'b0);
      tick_big();
      if (big_last_ready) accepted++;
    end
    check_output("fill_accepted", accepted, BIG + 2);
    check_output("fill_in_ready", 32'(big_last_ready), 0);
    check_output("fill_count", big_last_count, BIG + 2);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    tick_big();
    check_output("full_pop_same_cycle_ready", 32'(big_last_ready), 0);
    tick_big();
    check_output("full_pop_next_cycle_ready", 32'(big_last_ready), 1);
    n = 0;
    while (big_q.size() != 0 && n < 200) begin
      tick_big();
      n++;
    end
    check_output("drain_done", big_q.size(), 0);
    tick_big();
    check_output("drain_count", big_last_count, 0);
    check_output("drain_valid", 32'(big_last_valid), 0);

    // Mid-operation reset with a read in flight.
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1, 8'(8'h40 + i), 1'b0);
      tick_big();
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) tick_big();
    apply_stimulus(1'b0, 8'h00, 1'b1);
    tick_big();
    apply_stimulus(1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    tick_big();
    rst_n = 1'b1;
    tick_big();
    check_output("midrst_out_valid", 32'(big_last_valid), 0);
    check_output("midrst_count", big_last_count, 0);
    apply_stimulus(1'b1, 8'h3C, 1'b0);
    tick_big();
    apply_stimulus(1'b0, 8'h00, 1'b0);
    found = 1'b0;
    n = 0;
    while (!found && n < 10) begin
      tick_big();
      found = big_last_valid;
      n++;
    end
    check_output("midrst_first_valid", 32'(found), 1);
    check_output("midrst_first_data", 32'(big_last_data), 32'h3C);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    tick_big();
    tick_big();
    check_output("midrst_final_count", big_last_count, 0);

    // Random traffic on the non-power-of-two instance.
    for (int i = 0; i < 10000; i++) begin
      phase = i / 1000;
      s_in_valid  = ($urandom % 100) < ((phase % 2 == 1) ? 80 : 40);
      s_in_data   = 8'($urandom);
      s_out_ready = ($urandom % 100) < ((phase % 3 == 0) ? 20 : 70);
      tick_small();
    end
    s_in_valid  = 1'b0;
    s_out_ready = 1'b1;
    n = 0;
    while (small_q.size() != 0 && n < 50) begin
      tick_small();
      n++;
    end
    check_output("small_drain_done", small_q.size(), 0);
    tick_small();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Synchronous FIFO controller that turns the team's simple dual-port RAM (registered read, 1-cycle read latency, no reset) into a valid/ready stream FIFO. It sits directly around the RAM: upstream, it drives the RAM write port from an input stream; downstream, it issues RAM reads and consumes the RAM's registered read data into a 2-entry output buffer. That buffer hides the read latency and gives full throughput under backpressure.

## Interface
- RAM_SIZE, 64: RAM depth in words; any value ≥ 2, need not be a power of two.
- DATA_WIDTH, 8: word width.
- ADDR_WIDTH, localparam $clog2(RAM_SIZE): RAM address width.
- CNT_WIDTH, localparam $clog2(RAM_SIZE+3): occupancy width.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_data  in  DATA_WIDTH  write word.
- in_valid  in  1  write request.
- in_ready  out  1  FIFO can accept a word.
- out_data  out  DATA_WIDTH  head of output buffer.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the head word.
- count  out  CNT_WIDTH  total words held (RAM + in-flight + buffer).
- ram_data_in  out  DATA_WIDTH  to RAM data_in.
- ram_w_addr  out  ADDR_WIDTH  to RAM w_addr.
- ram_w_enable  out  1  to RAM w_enable.
- ram_r_addr  out  ADDR_WIDTH  to RAM r_addr.
- ram_data_out  in  DATA_WIDTH  from RAM data_out.

## Operation
- State:
  - wr_ptr and rd_ptr, each 0..RAM_SIZE-1, wrapping RAM_SIZE-1 → 0.
  - ram_level, 0..RAM_SIZE: words written to the RAM but not yet read.
  - pend, 1 bit: a read was issued last cycle.
  - buf_count, 0..2, with a 2-entry output buffer.
- push = in_valid & in_ready.
  - ram_w_enable = push; ram_w_addr = wr_ptr; ram_data_in = in_data (combinational pass-through).
  - On push, wr_ptr advances.
- in_ready = rst_n & (ram_level != RAM_SIZE). It depends only on registered state and never on out_ready.
- pop = out_valid & out_ready. out_valid = (buf_count != 0). out_data = buffer head.
- rd_issue = (ram_level != 0) & (buf_count + pend − pop < 2).
  - ram_r_addr = rd_ptr at all times.
  - On rd_issue, rd_ptr advances and pend is set for the next cycle; otherwise pend clears.
- When pend = 1, ram_data_out is written into the output buffer at the buffer tail that cycle. The buffer never overflows, by construction of rd_issue.
- ram_level next = ram_level + push − rd_issue. Simultaneous push and rd_issue leaves it unchanged.
- buf_count next = buf_count + pend − pop.
- count = ram_level + pend + buf_count; the maximum is RAM_SIZE + 2.
- Same-address hazard: a word written in cycle t is not read before cycle t+1, so the RAM never sees r_addr == w_addr with a read issued on that write.
- Reset (rst_n low at an edge):
  - wr_ptr, rd_ptr, ram_level, pend and buf_count all clear to 0.
  - Outputs during and after reset: out_valid=0, count=0, in_ready=0 while rst_n is low, ram_w_enable=0.
  - RAM contents are not cleared; all FIFO data is discarded.
  - Reset mid-operation drops in-flight reads; data_out captured in that cycle is ignored.

## Timing
- Write-to-read latency (empty FIFO): push in cycle t → rd_issue in t+1 → RAM data valid and captured in t+2 → out_valid = 1 in t+3.
- Throughput: one push and one pop per cycle sustained, with out_ready held high.
- Backpressure: with out_ready low, at most 2 words wait in the buffer. Reads stall and the RAM absorbs the rest.
- Full: in_ready goes low the cycle after ram_level reaches RAM_SIZE. The total count is then RAM_SIZE + 2 once the buffer is full.
- Empty: out_valid drops in the cycle after the last pop, unless pend refills the buffer.
- When the FIFO is full, a simultaneous pop does not raise in_ready in the same cycle. in_ready rises the cycle after a read is issued.

## Test plan
- Single word, RAM_SIZE=64, out_ready=1: push 0xA5 in cycle 10 → out_valid=1 with out_data=0xA5 in cycle 13 → count returns to 0 in cycle 14.
- Streaming: push 0..199 back-to-back with out_ready=1 → outputs 0..199 in order, one per cycle after the initial 3-cycle latency. Pointers wrap through 63 → 0 with no gaps.
- Fill: out_ready=0 with in_valid held → exactly 66 words accepted, in_ready=0 afterwards and count=66. Then release out_ready=1 → all 66 words drain in order and count ends at 0.
- Random stall: random in_valid and out_ready with RAM_SIZE=5 (non-power-of-two) for 10k cycles. A scoreboard checks ordering, no loss or duplication, and count ≤ 7.
- Mid-operation reset: with 20 words held and a read pending, pull rst_n low for 1 cycle → next cycle out_valid=0 and count=0. After rst_n is high, pushing 0x3C yields 0x3C as the first output.
- Reset hold: with rst_n low and in_valid=1 → in_ready=0 and ram_w_enable=0 throughout reset.
